szg_i2s2_mono_mixer: RTL and testbench

Parametrised stereo-to-mono mixer between the I2S2 PMOD PHY and the FrontPanel/DAC sample path. It pairs each left/right sample frame from the PHY, combines the two channels according to a run-time mode, and applies a ramped (pop-free) volume gain. The result is saturated back to sample width and emitted with a valid strobe. It replaces the fixed averaging and unused volume input of the previous top level with a fully pipelined, signed, overflow-safe datapath.

---
 rtl/szg_i2s2_mono_mixer_if.sv | 29 ++
 rtl/szg_i2s2_mono_mixer.sv | 141 ++++++++++++++
 tb/tb_szg_i2s2_mono_mixer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/szg_i2s2_mono_mixer_if.sv
// szg_i2s2_mono_mixer_if: sample/control bundle between the I2S2 PHY
// side (master) and the mono mixer (slave).
interface szg_i2s2_mono_mixer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8
);
    logic signed [DATA_WIDTH-1:0] l_channel;
    logic signed [DATA_WIDTH-1:0] r_channel;
    logic                         in_valid;
    logic [1:0]                   mode;
    logic [GAIN_WIDTH-1:0]        gain;
    logic                         clip_clear;
    logic signed [DATA_WIDTH-1:0] data;
    logic                         out_valid;
    logic                         clip;
    logic [GAIN_WIDTH-1:0]        cur_gain;

    modport master (
        output l_channel, r_channel, in_valid,
        output mode, gain, clip_clear,
        input  data, out_valid, clip, cur_gain
    );

    modport slave (
        input  l_channel, r_channel, in_valid,
        input  mode, gain, clip_clear,
        output data, out_valid, clip, cur_gain
    );
endinterface

// File: rtl/szg_i2s2_mono_mixer.sv
// szg_i2s2_mono_mixer: stereo-to-mono combine, ramped gain, saturation.
// Three registered stages: combine, scale, normalise/saturate.
module szg_i2s2_mono_mixer #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input logic clk,
    input logic reset,
    szg_i2s2_mono_mixer_if.slave bus
);
    localparam int XW = DATA_WIDTH + 1;
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 2;
    localparam int GMAX = (1 << GAIN_WIDTH) - 1;
    localparam int STEP_C = (RAMP_STEP > GMAX) ? GMAX : RAMP_STEP;
    localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(STEP_C);
    localparam logic signed [PW-1:0] SMAX =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] M_AVG   = 2'd0;
    localparam logic [1:0] M_LEFT  = 2'd1;
    localparam logic [1:0] M_RIGHT = 2'd2;
    localparam logic [1:0] M_SUM   = 2'd3;

    logic signed [XW-1:0] l_x;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] comb_val;

    always_comb begin
        l_x = {bus.l_channel[DATA_WIDTH-1], bus.l_channel};
        r_x = {bus.r_channel[DATA_WIDTH-1], bus.r_channel};
        sum_x = l_x + r_x;
        comb_val = sum_x;
        unique case (1'b1)
            bus.mode == M_AVG:   comb_val = sum_x >>> 1;
            bus.mode == M_LEFT:  comb_val = l_x;
            bus.mode == M_RIGHT: comb_val = r_x;
            bus.mode == M_SUM:   comb_val = sum_x;
        endcase
    end

    logic                  s1_valid;
    logic signed [XW-1:0]  s1_val;
    logic [GAIN_WIDTH-1:0] s1_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_val    <= '0;
            s1_target <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_val    <= comb_val;
                s1_target <= bus.gain;
            end
        end
    end

    logic [GAIN_WIDTH-1:0] cur_gain;
    logic [GAIN_WIDTH-1:0] next_gain;
    logic signed [PW-1:0]  prod;

    // Step toward the target, landing on it exactly rather than overshooting.
    always_comb begin
        next_gain = cur_gain;
        if (s1_target > cur_gain) begin
            next_gain = (s1_target - cur_gain > STEP) ?
                        cur_gain + STEP : s1_target;
        end else if (s1_target < cur_gain) begin
            next_gain = (cur_gain - s1_target > STEP) ?
                        cur_gain - STEP : s1_target;
        end
        prod = PW'(s1_val) * PW'($signed({1'b0, cur_gain}));
    end

    logic                 s2_valid;
    logic signed [PW-1:0] s2_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            cur_gain <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod  <= prod;
                cur_gain <= next_gain;
            end
        end
    end

    logic signed [PW-1:0]         norm;
    logic                         hi_clamp;
    logic                         lo_clamp;
    logic signed [DATA_WIDTH-1:0] sat_val;

    always_comb begin
        norm = s2_prod >>> (GAIN_WIDTH - 1);
        hi_clamp = norm > SMAX;
        lo_clamp = norm < SMIN;
        sat_val = norm[DATA_WIDTH-1:0];
        if (hi_clamp) begin
            sat_val = SMAX[DATA_WIDTH-1:0];
        end else if (lo_clamp) begin
            sat_val = SMIN[DATA_WIDTH-1:0];
        end
    end

    logic                         out_valid_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic                         clip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            clip_q      <= 1'b0;
        end else begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                data_q <= sat_val;
            end
            // A new clip outranks a simultaneous clear.
            if (s2_valid && (hi_clamp || lo_clamp)) begin
                clip_q <= 1'b1;
            end else if (bus.clip_clear) begin
                clip_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.clip      = clip_q;
    assign bus.cur_gain  = cur_gain;
endmodule

// File: tb/tb_szg_i2s2_mono_mixer.sv
// tb_szg_i2s2_mono_mixer: randomized bench against an arithmetic
// reference model of the mixer (combine, ramped gain, saturate).
module tb_szg_i2s2_mono_mixer;
  localparam int DW = 24;
  localparam int GW = 8;
  localparam int STEP = 1;
  localparam int UNITY = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  szg_i2s2_mono_mixer_if #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) bus ();

  szg_i2s2_mono_mixer #(
    .DATA_WIDTH(DW),
    .GAIN_WIDTH(GW),
    .RAMP_STEP(STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int             cyc;
    logic [DW-1:0]  d;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  gm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.out_valid) obs_q.push_back('{cyc, bus.data});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint ref_mix(input logic [DW-1:0] l,
                                     input logic [DW-1:0] r,
                                     input logic [1:0] m,
                                     input int g);
    longint lv, rv, v, y, hi, lo;
    lv = longint'($signed(l));
    rv = longint'($signed(r));
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    case (m)
      2'd0:    v = fdiv(lv + rv, 2);
      2'd1:    v = lv;
      2'd2:    v = rv;
      default: v = lv + rv;
    endcase
    y = fdiv(v * g, UNITY);
    if (y > hi) y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

  task automatic drive_frame(input logic [DW-1:0] l,
                             input logic [DW-1:0] r,
                             input logic [1:0] m,
                             input int g);
    longint y;
    bus.l_channel = l;
    bus.r_channel = r;
    bus.mode = m;
    bus.gain = GW'(g);
    bus.in_valid = 1'b1;
    y = ref_mix(l, r, m, gm);
    exp_q.push_back('{cyc + 3, y[DW-1:0]});
    if (gm < g) gm = gm + ((g - gm > STEP) ? STEP : g - gm);
    else if (gm > g) gm = gm - ((gm - g > STEP) ? STEP : gm - g);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.l_channel = DW'($urandom);
    bus.r_channel = DW'($urandom);
    bus.gain = 8'd200;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    gm = 0;
    n_chk++;
    if (bus.data !== '0) $display("FAIL reset data: got %h want 0", bus.data);
    else n_pass++;
    n_chk++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_chk++;
    if (bus.clip !== 1'b0) $display("FAIL reset clip: got %b want 0", bus.clip);
    else n_pass++;
    n_chk++;
    if (bus.cur_gain !== '0) $display("FAIL reset cur_gain: got %0d want 0", bus.cur_gain);
    else n_pass++;
    idle(6);
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL reset in_valid ignored: got %0d outputs want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_ramp();
    ev_t o, e;
    for (int k = 0; k < 132; k++) begin
      drive_frame(24'h100000, DW'($urandom), 2'd1, 128);
      idle(1);
      n_chk++;
      if (bus.cur_gain !== GW'(gm))
        $display("FAIL ramp cur_gain: frame %0d got %0d want %0d", k, bus.cur_gain, gm);
      else n_pass++;
      idle(2);
    end
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL ramp count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL ramp out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_modes();
    ev_t o, e;
    drive_frame(24'h7FFFFF, 24'h000001, 2'd0, 128);
    idle(3);
    drive_frame(24'hFFFFFD, 24'h000000, 2'd0, 128);
    idle(3);
    drive_frame(DW'($urandom), 24'h123456, 2'd2, 128);
    idle(3);
    for (int k = 0; k < 24; k++) begin
      drive_frame(DW'($urandom), DW'($urandom), 2'($urandom), 128);
      idle($urandom_range(0, 3));
    end
    idle(1);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL modes count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL modes out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    for (int k = 0; k < 10; k++)
      drive_frame(DW'($urandom), DW'($urandom), (k % 2 == 0) ? 2'd0 : 2'd3, 138);
    idle(1);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (bus.cur_gain !== GW'(gm))
      $display("FAIL b2b cur_gain: got %0d want %0d", bus.cur_gain, gm);
    else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL b2b out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    ev_t o, e;
    for (int k = 0; k < 10; k++) drive_frame('0, '0, 2'd1, 128);
    idle(4);
    bus.clip_clear = 1'b1;
    idle(1);
    bus.clip_clear = 1'b0;
    n_chk++;
    if (bus.clip !== 1'b0) $display("FAIL sat clear0: got %b want 0", bus.clip);
    else n_pass++;
    drive_frame(24'h600000, 24'h600000, 2'd3, 128);
    idle(4);
    n_chk++;
    if (bus.clip !== 1'b1) $display("FAIL sat pos clip: got %b want 1", bus.clip);
    else n_pass++;
    drive_frame(24'hA00000, 24'hA00000, 2'd3, 128);
    idle(4);
    bus.clip_clear = 1'b1;
    idle(1);
    bus.clip_clear = 1'b0;
    n_chk++;
    if (bus.clip !== 1'b0) $display("FAIL sat clear1: got %b want 0", bus.clip);
    else n_pass++;
    for (int k = 0; k < 130; k++) drive_frame('0, DW'($urandom), 2'd1, 255);
    idle(4);
    n_chk++;
    if (bus.cur_gain !== 8'd255) $display("FAIL sat gain top: got %0d want 255", bus.cur_gain);
    else n_pass++;
    drive_frame(24'h400000, DW'($urandom), 2'd1, 255);
    idle(4);
    n_chk++;
    if (bus.clip !== 1'b0) $display("FAIL sat gain255 noclip: got %b want 0", bus.clip);
    else n_pass++;
    drive_frame(24'h500000, DW'($urandom), 2'd1, 255);
    idle(1);
    bus.clip_clear = 1'b1;
    idle(1);
    bus.clip_clear = 1'b0;
    idle(2);
    n_chk++;
    if (bus.clip !== 1'b1) $display("FAIL sat set_wins: got %b want 1", bus.clip);
    else n_pass++;
    for (int k = 0; k < 130; k++) drive_frame('0, '0, 2'd1, 128);
    idle(1);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (bus.cur_gain !== 8'd128) $display("FAIL sat gain back: got %0d want 128", bus.cur_gain);
    else n_pass++;
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL sat count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL sat out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_ramp_down();
    ev_t o, e;
    for (int k = 0; k < 12; k++) begin
      drive_frame(DW'($urandom), DW'($urandom), 2'd1, 120);
      idle(1);
      n_chk++;
      if (bus.cur_gain !== GW'(gm))
        $display("FAIL rdown cur_gain: frame %0d got %0d want %0d", k, bus.cur_gain, gm);
      else n_pass++;
      idle(2);
    end
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL rdown count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL rdown out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t o, e;
    drive_frame(24'h300000, DW'($urandom), 2'd1, 128);
    drive_frame(24'h200000, DW'($urandom), 2'd1, 128);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    gm = 0;
    n_chk++;
    if (bus.data !== '0) $display("FAIL rmid data: got %h want 0", bus.data);
    else n_pass++;
    n_chk++;
    if (bus.clip !== 1'b0) $display("FAIL rmid clip: got %b want 0", bus.clip);
    else n_pass++;
    n_chk++;
    if (bus.cur_gain !== '0) $display("FAIL rmid cur_gain: got %0d want 0", bus.cur_gain);
    else n_pass++;
    idle(6);
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL rmid flushed: got %0d outputs want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    drive_frame(DW'($urandom), DW'($urandom), 2'($urandom), 128);
    idle(1);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL rmid count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.d !== e.d || o.cyc != e.cyc)
        $display("FAIL rmid out: got %h@%0d want %h@%0d", o.d, o.cyc, e.d, e.cyc);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.l_channel = '0;
    bus.r_channel = '0;
    bus.in_valid = 1'b0;
    bus.mode = 2'd0;
    bus.gain = '0;
    bus.clip_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_modes();
    test_back_to_back();
    test_saturation();
    test_ramp_down();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
